// File: rtl/code_lock_param.sv
// Parametrised digit-code lock: compares full-length keypad entries against a
// reprogrammable code, opens for a fixed window, and locks out after repeated failures.
module code_lock_param #(
    parameter int DIGIT_W     = 3,
    parameter int CODE_LEN    = 3,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = {3'b011, 3'b111, 3'b101},
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 16,
    parameter int OPEN_CYC    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          x_valid,
    input  logic [DIGIT_W-1:0]            x,
    input  logic                          prog_en,
    output logic                          y,
    output logic                          locked_out,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
    output logic                          code_changed
);

    localparam int CODE_W  = CODE_LEN * DIGIT_W;
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int MAX_CYC = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(CODE_LEN - 1);
    localparam logic [TMR_W-1:0]  OPEN_LAST  = TMR_W'(OPEN_CYC - 1);
    localparam logic [TMR_W-1:0]  LOCK_LAST  = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [FAIL_W:0]   MAX_FAIL_V = (FAIL_W + 1)'(MAX_FAIL);
    localparam logic [FAIL_W-1:0] FAIL_SAT   = FAIL_W'(MAX_FAIL);

    typedef enum logic [1:0] {
        S_ENTRY   = 2'd0,
        S_OPEN    = 2'd1,
        S_PROG    = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t              state_r, state_n;
    logic [IDX_W-1:0]    idx_r, idx_n;
    logic                mismatch_r, mismatch_n;
    logic [CODE_W-1:0]   code_r, code_n;
    logic [CODE_W-1:0]   stage_r, stage_n;
    logic [TMR_W-1:0]    timer_r, timer_n;
    logic [FAIL_W-1:0]   fail_cnt_r, fail_cnt_n;
    logic                y_r, y_n;
    logic                locked_out_r, locked_out_n;
    logic                code_changed_r, code_changed_n;
    logic                digit_ok_s;
    logic [FAIL_W:0]     fail_inc_s;
    logic [CODE_W-1:0]   stage_shift_s;

    // Digit idx of a code word; digit 0 occupies the MSBs.
    function automatic logic [DIGIT_W-1:0] code_digit(input logic [CODE_W-1:0] code,
                                                      input logic [IDX_W-1:0]  idx);
        logic [DIGIT_W-1:0] d;
        d = code[CODE_W-1 -: DIGIT_W];
        for (int i = 0; i < CODE_LEN; i++) begin
            if (idx == IDX_W'(i)) begin
                d = code[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
        return d;
    endfunction

    // Next-state and registered-output computation.
    always_comb begin
        state_n        = state_r;
        idx_n          = idx_r;
        mismatch_n     = mismatch_r;
        code_n         = code_r;
        stage_n        = stage_r;
        timer_n        = timer_r;
        fail_cnt_n     = fail_cnt_r;
        code_changed_n = 1'b0;
        digit_ok_s     = (x == code_digit(code_r, idx_r));
        fail_inc_s     = {1'b0, fail_cnt_r} + (FAIL_W + 1)'(1'b1);
        stage_shift_s  = (stage_r << DIGIT_W) | CODE_W'(x);

        case (state_r)
            S_ENTRY: begin
                if (x_valid) begin
                    if (idx_r == IDX_LAST) begin
                        idx_n      = IDX_W'(1'b0);
                        mismatch_n = 1'b0;
                        timer_n    = TMR_W'(1'b0);
                        if (digit_ok_s && !mismatch_r) begin
                            state_n    = S_OPEN;
                            fail_cnt_n = FAIL_W'(1'b0);
                        end else if (fail_inc_s >= MAX_FAIL_V) begin
                            state_n    = S_LOCKOUT;
                            fail_cnt_n = FAIL_SAT;
                        end else begin
                            fail_cnt_n = fail_inc_s[FAIL_W-1:0];
                        end
                    end else begin
                        idx_n      = idx_r + IDX_W'(1'b1);
                        mismatch_n = mismatch_r | ~digit_ok_s;
                    end
                end else begin
                    idx_n = idx_r;
                end
            end
            S_OPEN: begin
                // Programming request takes priority over window expiry.
                if (prog_en) begin
                    state_n = S_PROG;
                    idx_n   = IDX_W'(1'b0);
                    stage_n = CODE_W'(1'b0);
                    timer_n = TMR_W'(1'b0);
                end else if (timer_r == OPEN_LAST) begin
                    state_n = S_ENTRY;
                    timer_n = TMR_W'(1'b0);
                end else begin
                    timer_n = timer_r + TMR_W'(1'b1);
                end
            end
            S_PROG: begin
                if (x_valid) begin
                    stage_n = stage_shift_s;
                    if (idx_r == IDX_LAST) begin
                        code_n         = stage_shift_s;
                        code_changed_n = 1'b1;
                        state_n        = S_ENTRY;
                        idx_n          = IDX_W'(1'b0);
                    end else begin
                        idx_n = idx_r + IDX_W'(1'b1);
                    end
                end else begin
                    stage_n = stage_r;
                end
            end
            S_LOCKOUT: begin
                if (timer_r == LOCK_LAST) begin
                    state_n    = S_ENTRY;
                    fail_cnt_n = FAIL_W'(1'b0);
                    timer_n    = TMR_W'(1'b0);
                end else begin
                    timer_n = timer_r + TMR_W'(1'b1);
                end
            end
            default: begin
                state_n = S_ENTRY;
                idx_n   = IDX_W'(1'b0);
                timer_n = TMR_W'(1'b0);
            end
        endcase

        y_n          = (state_n == S_OPEN);
        locked_out_n = (state_n == S_LOCKOUT);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r        <= S_ENTRY;
            idx_r          <= IDX_W'(1'b0);
            mismatch_r     <= 1'b0;
            code_r         <= DEFAULT_CODE;
            stage_r        <= CODE_W'(1'b0);
            timer_r        <= TMR_W'(1'b0);
            fail_cnt_r     <= FAIL_W'(1'b0);
            y_r            <= 1'b0;
            locked_out_r   <= 1'b0;
            code_changed_r <= 1'b0;
        end else begin
            state_r        <= state_n;
            idx_r          <= idx_n;
            mismatch_r     <= mismatch_n;
            code_r         <= code_n;
            stage_r        <= stage_n;
            timer_r        <= timer_n;
            fail_cnt_r     <= fail_cnt_n;
            y_r            <= y_n;
            locked_out_r   <= locked_out_n;
            code_changed_r <= code_changed_n;
        end
    end

    assign y            = y_r;
    assign locked_out   = locked_out_r;
    assign fail_cnt     = fail_cnt_r;
    assign code_changed = code_changed_r;

endmodule

// File: doc/code_lock_param.md
# code_lock_param

Parametrised successor to the fixed 3-digit lock FSM. It accepts a stream of DIGIT_W-bit digits qualified by a valid strobe and compares each full CODE_LEN-digit entry against a reprogrammable code register. A correct entry opens the lock for a fixed window, and the code can be reprogrammed only while the lock is open. Consecutive failed entries trigger a timed lockout. The block sits between the keypad decoder and the actuator driver.

## Interface
- DIGIT_W, 3: bits per digit.
- CODE_LEN, 3: digits per code, ≥1.
- DEFAULT_CODE, {3'b011,3'b111,3'b101}: reset code, CODE_LEN*DIGIT_W bits; the first digit sits in the MSBs.
- MAX_FAIL, 3: consecutive failed entries that trigger lockout, ≥1.
- LOCKOUT_CYC, 16: lockout duration in clk cycles, ≥1.
- OPEN_CYC, 4: unlock window in clk cycles, ≥1.
- clk  in  1  the single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- x_valid  in  1  digit strobe; the digit on x is accepted on every edge where x_valid=1 and the FSM accepts digits.
- x  in  DIGIT_W  digit value.
- prog_en  in  1  request to program a new code; honoured only while the lock is open.
- y  out  1  unlock output; high while in OPEN.
- locked_out  out  1  high while in LOCKOUT.
- fail_cnt  out  $clog2(MAX_FAIL+1)  count of consecutive failed entries.
- code_changed  out  1  one-cycle pulse when a new code has been committed.

## Operation
- States: ENTRY, OPEN, PROG, LOCKOUT. All outputs are registered.
- Reset (reset=0 at an edge) takes effect in any state, including mid-entry, mid-OPEN, mid-PROG and mid-LOCKOUT. It sets:
  - state=ENTRY, digit index idx=0, mismatch flag=0;
  - code register=DEFAULT_CODE;
  - y=0, locked_out=0, fail_cnt=0, code_changed=0;
  - all timers=0.
- ENTRY: each accepted digit is compared with code digit idx, then idx increments. Any mismatch sets the sticky mismatch flag.
  - The entry is never aborted early: exactly CODE_LEN digits are always consumed.
  - On the digit that makes idx reach CODE_LEN, the whole entry is evaluated, then idx and the mismatch flag clear.
  - Pass (this digit matches and the flag was clear): go to OPEN, fail_cnt=0.
  - Fail, with fail_cnt+1 < MAX_FAIL: fail_cnt increments and the FSM stays in ENTRY.
  - Fail, with fail_cnt+1 = MAX_FAIL: fail_cnt=MAX_FAIL, go to LOCKOUT.
- OPEN: y=1 for OPEN_CYC cycles, then go to ENTRY with y=0.
  - x_valid is ignored.
  - If prog_en=1 at any OPEN edge, go to PROG instead; y drops to 0 at that edge.
- PROG: accepted digits are shifted into a staging register; the first digit lands in the MSBs. idx counts the digits.
  - On the CODE_LEN-th digit, the code register takes the staged value and code_changed=1 for exactly one cycle. Go to ENTRY, idx=0.
  - prog_en is don't-care once the FSM is in PROG.
- LOCKOUT: locked_out=1 and x_valid is ignored for LOCKOUT_CYC cycles. Then go to ENTRY with locked_out=0 and fail_cnt=0.
- Timers are $clog2(max(OPEN_CYC,LOCKOUT_CYC)+1) bits wide. They load 0 on state entry and leave the state when the count reaches N-1. Timers must never wrap.
- fail_cnt saturates at MAX_FAIL and is never incremented past it.
- Gaps between digits (x_valid=0) are unbounded and do not time out a partial entry.

## Timing
- A digit is sampled on edge E when x_valid=1. State, y, locked_out, fail_cnt and code_changed change at that same edge E and are visible in the cycle after E.
- Unlock latency: y is high in cycles E+1 … E+OPEN_CYC after the final correct digit is sampled at edge E.
- Lockout: locked_out is high for exactly LOCKOUT_CYC cycles starting at E+1. The first digit accepted after lockout is the one sampled at edge E+LOCKOUT_CYC+1 or later.
- Back-to-back digits (x_valid=1 every cycle) are supported at full rate in ENTRY and PROG.
- A digit presented on the same edge as the OPEN→ENTRY or LOCKOUT→ENTRY transition is ignored.
- Simultaneous x_valid=1 and reset=0: reset wins, and the digit is dropped.

## Test plan
- Reset, then x_valid pulses with digits 3,7,5 (default parameters) → y=1 for exactly 4 cycles starting the cycle after the 5 is sampled; fail_cnt=0.
- Digits 3,0,5 → no y; fail_cnt=1. Then 3,7,5 → y opens; fail_cnt returns to 0. This also checks that a bad middle digit does not abort the entry early.
- Three wrong entries (0,0,0 ×3) → locked_out=1 for 16 cycles after the ninth digit. Digits 3,7,5 sent during lockout are ignored (y stays 0). After lockout, fail_cnt=0 and 3,7,5 opens.
- Open with 3,7,5, assert prog_en, enter 1,2,4 → code_changed pulses once and y=0. Then 3,7,5 fails (fail_cnt=1) and 1,2,4 opens.
- Apply reset=0 during PROG after 2 digits, and again mid-lockout → every output returns to its reset value, and the code register reverts to DEFAULT_CODE (3,7,5 opens).
- Parameter sweep DIGIT_W=4, CODE_LEN=6, MAX_FAIL=1, OPEN_CYC=1 → a single wrong entry locks out immediately; a correct entry gives a one-cycle y pulse.
